// File: rtl/bus_arb_bcast.sv
// bus_arb_bcast: shared-bus arbiter moving one packet per 3-cycle transaction, with broadcast and drop counting
module bus_arb_bcast #(
    parameter int         pckg_sz = 24,
    parameter int         drvrs   = 4,
    parameter logic [7:0] bcst    = 8'hFF,
    parameter int         cnt_w   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rr_mode,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [drvrs*pckg_sz-1:0] D_push,
    output logic [cnt_w-1:0]         pkt_cnt,
    output logic [cnt_w-1:0]         err_cnt,
    output logic                     busy
);
    localparam int sw = $clog2(drvrs);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t            state, state_nx;
    logic [sw-1:0]     src, rr_ptr, win, idx;
    logic              found;
    logic [pckg_sz-1:0] pkt;
    logic [7:0]        dst;
    logic              legal, is_bcst;

    assign dst     = pkt[pckg_sz-1 -: 8];
    assign legal   = int'(dst) < drvrs;
    assign is_bcst = dst == bcst;
    assign D_push  = {drvrs{pkt}};
    assign busy    = state != IDLE;

    // Winner search: scan starts at rr_ptr in round-robin mode, at 0 in fixed mode
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < drvrs; k++) begin
            idx = rr_mode ? sw'((int'(rr_ptr) + k) % drvrs) : sw'(k);
            if (!found && pndng[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: IDLE is the only arbitration point, POP and PUSH last one cycle each
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |pndng ? POP : IDLE;
            POP:     state_nx = PUSH;
            PUSH:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes decoded only from registered state, src and pkt so inputs never reach them
    always_comb begin
        pop  = '0;
        push = '0;
        if (state == POP) pop[src] = 1'b1;
        if (state == PUSH)
            push = legal   ? drvrs'(1) << dst :
                   is_bcst ? ~(drvrs'(1) << src) : '0;
    end

    // Datapath: latch winner, capture packet and advance rr_ptr, then count the outcome
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src     <= '0;
            rr_ptr  <= '0;
            pkt     <= '0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (state == IDLE && |pndng) src <= win;
            if (state == POP) begin
                pkt    <= D_pop[src*pckg_sz +: pckg_sz];
                rr_ptr <= (int'(src) == drvrs - 1) ? '0 : src + 1'b1;
            end
            if (state == PUSH) begin
                if (legal || is_bcst) pkt_cnt <= pkt_cnt + 1'b1;
                else                  err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_arb_bcast.sv
// tb_bus_arb_bcast: scoreboard bench with FIFO models and a transaction-level reference model
module tb_bus_arb_bcast;
    localparam int P = 24;
    localparam int N = 4;

    logic           clk = 0, reset = 1, rr_mode = 0;
    logic [N-1:0]   pndng = '0;
    logic [N*P-1:0] d_pop = '0;
    logic [N-1:0]   pop, push;
    logic [N*P-1:0] d_push;
    logic [15:0]    pkt_cnt, err_cnt;
    logic           busy;

    bus_arb_bcast #(.pckg_sz(P), .drvrs(N), .bcst(8'hFF), .cnt_w(16)) dut (
        .clk(clk), .reset(reset), .rr_mode(rr_mode), .pndng(pndng), .D_pop(d_pop),
        .pop(pop), .push(push), .D_push(d_push), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pop;
        logic [N-1:0] push;
        logic [P-1:0] data;
        int           pkt;
        int           err;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    logic [P-1:0] fq[N][$];
    logic [P-1:0] mq[N][$];
    int checks = 0, errors = 0;
    int m_rr = 0, m_pkt = 0, m_err = 0;
    int stage = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Source FIFO models: dequeue on a pop edge, present head word shortly after
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (!reset && pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        #1;
        for (int i = 0; i < N; i++) begin
            pndng[i]        = fq[i].size() > 0;
            d_pop[i*P +: P] = fq[i].size() > 0 ? fq[i][0] : '0;
        end
    end

    // Monitor: pop opens a transaction, push follows one cycle later, counters one cycle after that
    initial forever begin
        @(negedge clk);
        if (!mon_en) stage = 0;
        else if (stage == 0) begin
            if (pop != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %b expected none", pop);
                end else begin
                    cur = exp_q.pop_front();
                    chk("pop", pop, cur.pop);
                    chk("busy_pop", busy, 1);
                    stage = 1;
                end
            end else if (push != 0) chk("stray_push", push, 0);
        end else if (stage == 1) begin
            chk("pop_len", pop, 0);
            chk("push", push, cur.push);
            chk("d_push", d_push, {N{cur.data}});
            stage = 2;
        end else begin
            chk("pkt_cnt", pkt_cnt, cur.pkt & 16'hFFFF);
            chk("err_cnt", err_cnt, cur.err & 16'hFFFF);
            chk("push_len", push, 0);
            chk("idle", busy, 0);
            stage = 0;
        end
    end

    task automatic add_w(input int s, input logic [P-1:0] w);
        fq[s].push_back(w);
        mq[s].push_back(w);
    endtask

    task automatic add(input int s, input logic [7:0] d);
        add_w(s, {d, 16'($urandom)});
    endtask

    // Reference: drain the loaded packets in grant order using the arbitration rules directly
    task automatic model_run(input bit mode);
        exp_t e;
        int   s;
        logic [7:0] d;
        forever begin
            s = -1;
            for (int k = 0; k < N && s < 0; k++) begin
                int j;
                j = mode ? (m_rr + k) % N : k;
                if (mq[j].size() > 0) s = j;
            end
            if (s < 0) break;
            e.data = mq[s].pop_front();
            e.pop  = N'(1) << s;
            d      = e.data[P-1 -: 8];
            m_rr   = (s + 1) % N;
            if (d < N) begin
                e.push = N'(1) << d;
                m_pkt++;
            end else if (d == 8'hFF) begin
                e.push = ~(N'(1) << s);
                m_pkt++;
            end else begin
                e.push = '0;
                m_err++;
            end
            e.pkt = m_pkt;
            e.err = m_err;
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input bit mode);
        bit done;
        model_run(mode);
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            #2;
            done = exp_q.size() == 0 && stage == 0 && !busy &&
                   fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bit mode;
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", d_push, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        reset  = 0;
        mon_en = 1;

        @(negedge clk);
        rr_mode = 1;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add(s, 8'($urandom_range(0, N - 1)));
        run(1);
        chk("rr_total", pkt_cnt, 8);

        @(negedge clk);
        rr_mode = 0;
        add_w(2, 24'h01ABCD);
        run(0);

        @(negedge clk);
        for (int r = 0; r < 3; r++) add(1, 8'($urandom_range(0, N - 1)));
        for (int r = 0; r < 2; r++) add(3, 8'($urandom_range(0, N - 1)));
        run(0);

        @(negedge clk);
        add(0, 8'hFF);
        run(0);

        @(negedge clk);
        add(3, 8'h07);
        run(0);

        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            mode    = 1'($urandom_range(0, 1));
            rr_mode = mode;
            for (int s = 0; s < N; s++)
                for (int r = $urandom_range(0, 3); r > 0; r--) begin
                    int c;
                    c = $urandom_range(0, 5);
                    add(s, c < 4 ? 8'(c) : c == 4 ? 8'hFF : 8'($urandom_range(4, 254)));
                end
            run(mode);
        end

        @(negedge clk);
        mon_en  = 0;
        rr_mode = 1;
        fq[1].push_back({8'd2, 16'h1234});
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = push != 0;
        end
        chk("push_before_reset", seen, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_push", push, 0);
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pkt", pkt_cnt, 0);
        chk("mid_rst_err", err_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        reset  = 0;
        m_rr   = 0;
        m_pkt  = 0;
        m_err  = 0;
        mon_en = 1;
        add(2, 8'd1);
        add(0, 8'd3);
        run(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arb_bcast.md
# bus_arb_bcast

Parametrised successor to the bus generator/arbiter: a single shared bus connecting `drvrs` device FIFOs. It arbitrates among pending sources using fixed-priority or round-robin selection, moves one packet per transaction to the destination named in the packet header, and supports broadcast. Packets with an out-of-range destination are dropped and counted.

## Interface

Parameters:

- `pckg_sz`, 24: total packet width in bits. Bits [pckg_sz-1:pckg_sz-8] are the destination ID; the rest is payload. Minimum is 9.
- `drvrs`, 4: number of devices, 2..255.
- `bcst`, 8'hFF: broadcast destination ID. It must be ≥ `drvrs`.
- `cnt_w`, 16: width of the statistics counters.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `rr_mode`, input, 1: arbitration mode, sampled in IDLE. 1 = round-robin, 0 = fixed priority (lowest index wins).
- `pndng`, input, drvrs: bit i high means source FIFO i is non-empty.
- `D_pop`, input, drvrs*pckg_sz: head word of FIFO i on slice [i*pckg_sz +: pckg_sz].
- `pop`, output, drvrs: one-hot dequeue strobe to source FIFOs.
- `push`, output, drvrs: enqueue strobes to destination FIFOs (multi-hot for broadcast).
- `D_push`, output, drvrs*pckg_sz: delivered packet, replicated on every slice.
- `pkt_cnt`, output, cnt_w: packets delivered. Broadcast counts once.
- `err_cnt`, output, cnt_w: packets dropped for an illegal destination.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation

- State machine, one-hot or encoded: IDLE, POP, PUSH.
  - **IDLE:** if `pndng` is non-zero at the clock edge, register winner `src` and go to POP. Otherwise stay.
    - Fixed mode: `src` is the lowest set index.
    - Round-robin mode: `src` is the first set index at or after `rr_ptr`, wrapping modulo `drvrs`.
  - **POP:** drive `pop[src]=1`. At the clock edge:
    - Latch `pkt <= D_pop[src]`.
    - Decode `dst = pkt[pckg_sz-1 -: 8]`.
    - Set `rr_ptr <= (src+1) mod drvrs`. This update happens in both modes.
    - Go to PUSH.
  - **PUSH:** drive `D_push` (all slices) with `pkt`, and drive `push` as follows:
    - `dst < drvrs`: `push = 1<<dst`. Self-addressed (`dst == src`) is delivered normally. Increment `pkt_cnt`.
    - `dst == bcst`: `push` has every bit except `src` set. Increment `pkt_cnt` by 1.
    - Otherwise: `push = 0`. Increment `err_cnt`. The packet is consumed and discarded.
    - Always return to IDLE.
- `pop` and `push` are decoded from registered state, `src` and `dst` only. They have no combinational path from `pndng` or `D_pop`.
- `D_push` holds its last value outside PUSH. It resets to 0.
- Counters wrap modulo 2^cnt_w.

## Timing

- Reset, asynchronous: state=IDLE, `rr_ptr`=0, `pop`=0, `push`=0, `D_push`=0, `pkt_cnt`=0, `err_cnt`=0, `busy`=0.
- Latency:
  - Edge E0 in IDLE samples `pndng`.
  - The cycle after E0 is POP, with `pop` high for exactly 1 cycle.
  - The next cycle is PUSH, with `push` high for exactly 1 cycle.
  - The counter update is visible after the edge that ends PUSH.
- Throughput: 1 packet per 3 cycles under continuous load.
- `pndng` changes during POP or PUSH are ignored. The only arbitration point is IDLE.
- Source FIFO contract: `D_pop` is valid while `pndng` is high, and the FIFO advances on the edge where `pop` is high. Destination FIFOs must accept `push` unconditionally; there is no back-pressure.
- Reset asserted in POP: `pop` drops immediately, no dequeue occurs and the packet stays in the FIFO.
- Reset asserted in PUSH: `push` drops immediately and the packet is lost. Neither counter increments.
- Round-robin wrap: with `rr_ptr = drvrs-1`, a win by `drvrs-1` sets `rr_ptr` to 0.

## Test plan

- Single packet, drvrs=4, pckg_sz=24:
  - Stimulus: `pndng=4'b0100`, `D_pop[2]=24'h01_ABCD`.
  - Required: `pop=4'b0100` in the cycle after the sampling edge, then `push=4'b0010` with `D_push` slices = 24'h01ABCD.
  - Afterwards `pkt_cnt=1`, and the whole transaction takes 3 cycles.
- Round-robin fairness:
  - Stimulus: `rr_mode=1`, `pndng=4'b1111` held, each FIFO holding 2 packets.
  - Required: `pop` sequence is 0,1,2,3,0,1,2,3 and `pkt_cnt=8`.
- Fixed priority:
  - Stimulus: `rr_mode=0`, `pndng=4'b1010` held.
  - Required: source 1 is granted every transaction while bit 1 stays set; source 3 is granted only after bit 1 clears.
- Broadcast:
  - Stimulus: source 0 sends `dst=8'hFF`.
  - Required: `push=4'b1110` for 1 cycle, and `pkt_cnt` increments by exactly 1.
- Illegal destination:
  - Stimulus: source 3 sends `dst=8'h07`.
  - Required: `pop[3]` pulses, `push` stays 0, `err_cnt=1`, `pkt_cnt` unchanged.
- Reset mid-transaction:
  - Stimulus: assert `reset` asynchronously during PUSH.
  - Required: `push`, `pop` and `busy` go to 0 before the next edge, both counters are 0, and after release arbitration resumes from `rr_ptr=0`.
